data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory request/response bus for data_mem_responder.
// The master drives requests and the slave (the responder) returns single-pulse responses.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data memory with fixed wait states, byte-lane stores, sign/zero-extended loads.
// Misaligned, illegal-size or out-of-range requests complete with rsp_err and leave memory untouched.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [2:0]  lat_func3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        cur_we;
    logic [2:0]  cur_func3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic        accept;
    logic        enter_resp;
    logic        err;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

`ifndef SYNTHESIS
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
    end
`endif

    assign accept = (state == IDLE) && bus.req_valid;

    // State register and request latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_func3 <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_func3 <= bus.req_func3;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= err;
                rdata_q <= (err || cur_we) ? '0 : load_data;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);

    // Outputs.
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // With zero wait states RESP is entered on the accept edge, before the
    // latches load, so decode works from the live bus while in IDLE.
    always_comb begin
        cur_we    = (state == IDLE) ? bus.req_we    : lat_we;
        cur_func3 = (state == IDLE) ? bus.req_func3 : lat_func3;
        cur_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
        cur_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
    end

    always_comb begin
        err         = 1'b0;
        be          = 4'b0000;
        wdata_lanes = cur_wdata;
        case (cur_func3)
            3'b000, 3'b100: begin
                be          = 4'b0001 << cur_addr[1:0];
                wdata_lanes = {4{cur_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                err         = cur_addr[0];
                be          = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{cur_wdata[15:0]}};
            end
            3'b010: begin
                err         = (cur_addr[1:0] != 2'b00);
                be          = 4'b1111;
                wdata_lanes = cur_wdata;
            end
            default: err = 1'b1;
        endcase
        if (cur_addr[31:ADDR_WIDTH+2] != '0) err = 1'b1;
    end

    always_comb begin
        word_idx  = cur_addr[ADDR_WIDTH+1:2];
        word      = mem[word_idx];
        byte_sel  = word[{cur_addr[1:0], 3'b000} +: 8];
        half_sel  = cur_addr[1] ? word[31:16] : word[15:0];
        load_data = '0;
        case (cur_func3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

    assign mem_we = enter_resp && cur_we && !err && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (be[n]) mem[word_idx][8*n +: 8] <= wdata_lanes[8*n +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench: one responder with one wait state, one with none.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel;
    logic        v;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;

    data_mem_responder_if b1 ();
    data_mem_responder_if b0 ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );

    assign b1.req_valid = v & ~sel;
    assign b0.req_valid = v & sel;
    assign b1.req_we    = we;
    assign b0.req_we    = we;
    assign b1.req_func3 = f3;
    assign b0.req_func3 = f3;
    assign b1.req_addr  = addr;
    assign b0.req_addr  = addr;
    assign b1.req_wdata = wdata;
    assign b0.req_wdata = wdata;

    logic        ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    assign ready     = sel ? b0.req_ready : b1.req_ready;
    assign rsp_valid = sel ? b0.rsp_valid : b1.rsp_valid;
    assign rsp_err   = sel ? b0.rsp_err   : b1.rsp_err;
    assign rsp_rdata = sel ? b0.rsp_rdata : b1.rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic compare_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
    endtask

    // Enter and leave on a negedge; inputs are scrambled after accept.
    task automatic do_req(input string tag, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee);
        int n;
        int lat;
        exp_t e;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        v = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1;
        v = 1'b0; we = ~w; f3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), sel ? 32'd1 : 32'd2);
        compare_rsp(tag);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int nrsp;
        sel = 1'b0; v = 1'b0; we = 1'b0; f3 = 3'b010; addr = '0; wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready",  {31'd0, b1.req_ready}, 32'd1);
        check("rst_valid",  {31'd0, b1.rsp_valid}, 32'd0);
        check("rst_rdata",  b1.rsp_rdata, 32'd0);
        check("rst_err",    {31'd0, b1.rsp_err}, 32'd0);
        check("rst_ready0", {31'd0, b0.req_ready}, 32'd1);
        reset = 1'b0;

        do_req("sw40",   1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw40",   1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("lb43",   1'b0, 3'b000, 32'h43, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req("lbu43",  1'b0, 3'b100, 32'h43, 32'h0, 32'h000000DE, 1'b0);
        do_req("lh42",   1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFFDEAD, 1'b0);
        do_req("lhu40",  1'b0, 3'b101, 32'h40, 32'h0, 32'h0000BEEF, 1'b0);
        do_req("sb41",   1'b1, 3'b000, 32'h41, 32'h55, 32'h0, 1'b0);
        do_req("lw40b",  1'b0, 3'b010, 32'h40, 32'h0, 32'hDEAD55EF, 1'b0);
        do_req("sh42",   1'b1, 3'b001, 32'h42, 32'h1234, 32'h0, 1'b0);
        do_req("lw40c",  1'b0, 3'b010, 32'h40, 32'h0, 32'h123455EF, 1'b0);
        do_req("lb40",   1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFEF, 1'b0);
        do_req("lw42e",  1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1);
        do_req("sh41e",  1'b1, 3'b001, 32'h41, 32'hFFFF, 32'h0, 1'b1);
        do_req("lw40d",  1'b0, 3'b010, 32'h40, 32'h0, 32'h123455EF, 1'b0);
        do_req("f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1);
        do_req("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
        do_req("sw1000", 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
        do_req("lw0",    1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset during the wait cycle of a store aborts it.
        v = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h80; wdata = 32'hAAAAAAAA;
        @(posedge clk);
        #1;
        v = 1'b0;
        @(negedge clk);
        check("wait_ready", {31'd0, b1.req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, b1.req_ready}, 32'd1);
        check("abort_valid", {31'd0, b1.rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nrsp = 0;
        repeat (4) begin
            @(negedge clk);
            if (b1.rsp_valid) nrsp++;
        end
        check("abort_norsp", 32'(nrsp), 32'd0);
        do_req("lw80", 1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b0);

        // Zero wait states: back-to-back loads with req_valid held high.
        sel = 1'b1;
        @(negedge clk);
        do_req("sw10_0", 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0);
        v = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h10;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_ready%0d", i), {31'd0, ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_valid%0d", i), {31'd0, rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (rsp_valid) compare_rsp($sformatf("b2b%0d", i));
            if (ready && v) begin
                exp_t e;
                e.rdata = 32'h11223344;
                e.err   = 1'b0;
                sb.push_back(e);
                acc++;
            end
            @(negedge clk);
        end
        v = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd4);
        if (rsp_valid) compare_rsp("b2b_last");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
